// File: rtl/lc3_pkg.sv
// lc3_pkg
//   Shared constants and mux encodings for the LC-3 style datapath blocks.
//   Contents:
//     DATA_W     - datapath / register width
//     NUM_REGS   - number of general-purpose registers
//     RESET_NZP  - condition codes after reset (Z set)
//     drmux_e    - destination-register select encodings
//     sr1mux_e   - SR1 read-port select encodings
package lc3_pkg;

  localparam int         DATA_W    = 16;
  localparam int         NUM_REGS  = 8;
  localparam logic [2:0] RESET_NZP = 3'b010;

  typedef enum logic [1:0] {
    DR_IR11_9 = 2'b00,
    DR_R7     = 2'b01,
    DR_R6     = 2'b10,
    DR_RSVD   = 2'b11
  } drmux_e;

  typedef enum logic [1:0] {
    SR1_IR11_9 = 2'b00,
    SR1_IR8_6  = 2'b01,
    SR1_R6     = 2'b10,
    SR1_RSVD   = 2'b11
  } sr1mux_e;

endpackage

// File: rtl/nzp_logic.sv
// nzp_logic
//   Combinational N/Z/P classification of a two's-complement value.
//   Exactly one output is high for any input value.
//   Ports:
//     value_i  [W-1:0]  value to classify
//     n_o               value is negative
//     z_o               value is zero
//     p_o               value is strictly positive
module nzp_logic #(
  parameter int W = 16
) (
  input  logic [W-1:0] value_i,
  output logic         n_o,
  output logic         z_o,
  output logic         p_o
);

  logic is_zero;

  assign is_zero = (value_i == '0);
  assign n_o     = value_i[W-1];
  assign z_o     = is_zero;
  assign p_o     = ~value_i[W-1] & ~is_zero;

endmodule

// File: rtl/reg_file_cc.sv
// reg_file_cc
//   General-purpose register file (R0-R7), ALU operand muxes, NZP condition
//   codes and the BEN branch-enable flag. Reads are combinational from the
//   registered state (no write-to-read bypass); all loads take one edge.
//   Ports:
//     i_Clk      system clock, rising edge
//     i_Rst_n    asynchronous active-low reset
//     i_Bus      write-back data and condition-code source
//     i_IR       current instruction register
//     i_LD_REG   write i_Bus into the register chosen by i_DRMUX
//     i_DRMUX    00 IR[11:9], 01 R7, 10 R6, 11 no write
//     i_SR1MUX   00 IR[11:9], 01 IR[8:6], 10 R6, 11 R0
//     i_LD_CC    load NZP from i_Bus
//     i_LD_BEN   load BEN from IR[11:9] and the current NZP
//     o_SR1_Out  R[sr1]
//     o_SR2_Out  sext(IR[4:0]) when IR[5]=1, else R[IR[2:0]]
//     o_N/o_Z/o_P condition-code flags
//     o_BEN      branch-enable flag
module reg_file_cc #(
  parameter int         DATA_W    = lc3_pkg::DATA_W,
  parameter int         NUM_REGS  = lc3_pkg::NUM_REGS,
  parameter logic [2:0] RESET_NZP = lc3_pkg::RESET_NZP
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [DATA_W-1:0] i_Bus,
  input  logic [15:0]       i_IR,
  input  logic              i_LD_REG,
  input  logic [1:0]        i_DRMUX,
  input  logic [1:0]        i_SR1MUX,
  input  logic              i_LD_CC,
  input  logic              i_LD_BEN,
  output logic [DATA_W-1:0] o_SR1_Out,
  output logic [DATA_W-1:0] o_SR2_Out,
  output logic              o_N,
  output logic              o_Z,
  output logic              o_P,
  output logic              o_BEN
);

  import lc3_pkg::*;

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [2:0]        nzp_q, nzp_d;
  logic              ben_q, ben_d;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  sr1_idx;
  logic [IDX_W-1:0]  sr2_idx;
  logic              bus_n, bus_z, bus_p;
  logic              ben_next;

  // Destination decode; the reserved encoding suppresses the write entirely.
  always_comb begin
    wr_en  = 1'b1;
    wr_idx = '0;
    case (drmux_e'(i_DRMUX))
      DR_IR11_9: wr_idx = IDX_W'(i_IR[11:9]);
      DR_R7:     wr_idx = IDX_W'(7);
      DR_R6:     wr_idx = IDX_W'(6);
      default:   wr_en  = 1'b0;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (i_LD_REG && wr_en) begin
      regs_d[wr_idx] = i_Bus;
    end
  end

  nzp_logic #(
    .W (DATA_W)
  ) u_nzp_logic (
    .value_i (i_Bus),
    .n_o     (bus_n),
    .z_o     (bus_z),
    .p_o     (bus_p)
  );

  // BEN samples nzp_q, i.e. the flags held before this edge, so a
  // simultaneous CC load does not affect the branch decision.
  assign ben_next = (i_IR[11] & nzp_q[2]) |
                    (i_IR[10] & nzp_q[1]) |
                    (i_IR[9]  & nzp_q[0]);

  always_comb begin
    nzp_d = nzp_q;
    ben_d = ben_q;
    if (i_LD_CC) begin
      nzp_d = {bus_n, bus_z, bus_p};
    end
    if (i_LD_BEN) begin
      ben_d = ben_next;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
      nzp_q <= RESET_NZP;
      ben_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      nzp_q  <= nzp_d;
      ben_q  <= ben_d;
    end
  end

  // Reserved SR1 select falls back to R0.
  always_comb begin
    sr1_idx = '0;
    case (sr1mux_e'(i_SR1MUX))
      SR1_IR11_9: sr1_idx = IDX_W'(i_IR[11:9]);
      SR1_IR8_6:  sr1_idx = IDX_W'(i_IR[8:6]);
      SR1_R6:     sr1_idx = IDX_W'(6);
      default:    sr1_idx = '0;
    endcase
  end

  assign sr2_idx   = IDX_W'(i_IR[2:0]);
  assign o_SR1_Out = regs_q[sr1_idx];
  assign o_SR2_Out = i_IR[5] ? {{(DATA_W-5){i_IR[4]}}, i_IR[4:0]}
                             : regs_q[sr2_idx];

  assign o_N   = nzp_q[2];
  assign o_Z   = nzp_q[1];
  assign o_P   = nzp_q[0];
  assign o_BEN = ben_q;

endmodule

// File: tb/tb_reg_file_cc.sv
module tb_reg_file_cc;

  logic        clk;
  logic        rst_n;
  logic [15:0] bus;
  logic [15:0] ir;
  logic        ld_reg;
  logic [1:0]  drmux;
  logic [1:0]  sr1mux;
  logic        ld_cc;
  logic        ld_ben;
  logic [15:0] sr1_out;
  logic [15:0] sr2_out;
  logic        n_f, z_f, p_f;
  logic        ben;

  reg_file_cc dut (
    .i_Clk     (clk),
    .i_Rst_n   (rst_n),
    .i_Bus     (bus),
    .i_IR      (ir),
    .i_LD_REG  (ld_reg),
    .i_DRMUX   (drmux),
    .i_SR1MUX  (sr1mux),
    .i_LD_CC   (ld_cc),
    .i_LD_BEN  (ld_ben),
    .o_SR1_Out (sr1_out),
    .o_SR2_Out (sr2_out),
    .o_N       (n_f),
    .o_Z       (z_f),
    .o_P       (p_f),
    .o_BEN     (ben)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [2:0]  nzp;
    logic        ben;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;

  // Reference model: architectural state only.
  logic [15:0] m_reg [8];
  logic [2:0]  m_nzp;
  logic        m_ben;

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_reg[k] = 16'h0000;
    m_nzp = 3'b010;
    m_ben = 1'b0;
  endtask

  // Effect of one rising edge given the inputs currently applied.
  task automatic model_edge();
    logic [2:0] old_nzp;
    int         dest;
    if (!rst_n) begin
      model_reset();
    end else begin
      old_nzp = m_nzp;
      dest = -1;
      if (drmux == 2'd0) dest = int'(ir[11:9]);
      else if (drmux == 2'd1) dest = 7;
      else if (drmux == 2'd2) dest = 6;
      if (ld_reg && dest >= 0) m_reg[dest] = bus;
      if (ld_cc) begin
        if ($signed(bus) < 0)  m_nzp = 3'b100;
        else if (bus == 16'd0) m_nzp = 3'b010;
        else                   m_nzp = 3'b001;
      end
      if (ld_ben) m_ben = |(ir[11:9] & old_nzp);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    int   sel;
    int   imm;
    if (sr1mux == 2'd0)      sel = int'(ir[11:9]);
    else if (sr1mux == 2'd1) sel = int'(ir[8:6]);
    else if (sr1mux == 2'd2) sel = 6;
    else                     sel = 0;
    e.id  = step_id;
    e.sr1 = m_reg[sel];
    if (ir[5]) begin
      imm = int'(ir[4:0]);
      if (imm >= 16) imm = imm - 32;
      e.sr2 = 16'(imm);
    end else begin
      e.sr2 = m_reg[int'(ir[2:0])];
    end
    e.nzp = m_nzp;
    e.ben = m_ben;
    exp_q.push_back(e);
  endtask

  // New inputs land 1 time unit after the edge; reset drops mid-cycle and
  // is reflected in the model immediately.
  task automatic step(input logic rst_v, input logic [15:0] b, input logic [15:0] irv,
                      input logic lr, input logic [1:0] dm, input logic [1:0] sm,
                      input logic lc, input logic lb);
    @(posedge clk);
    #1;
    model_edge();
    rst_n  = rst_v;
    bus    = b;
    ir     = irv;
    ld_reg = lr;
    drmux  = dm;
    sr1mux = sm;
    ld_cc  = lc;
    ld_ben = lb;
    if (!rst_v) model_reset();
    step_id++;
    push_expected();
  endtask

  // Read every register through both read ports, no loads.
  task automatic sweep(input logic rst_v);
    for (int k = 0; k < 8; k++) begin
      step(rst_v, 16'h0000, 16'((k << 6) | k), 1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
    end
  endtask

  // Monitor: one expectation per cycle, checked on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sr1_out !== e.sr1) begin
          failures++;
          $display("FAIL sr1 step=%0d actual=%h required=%h", e.id, sr1_out, e.sr1);
        end
        checks++;
        if (sr2_out !== e.sr2) begin
          failures++;
          $display("FAIL sr2 step=%0d actual=%h required=%h", e.id, sr2_out, e.sr2);
        end
        checks++;
        if ({n_f, z_f, p_f} !== e.nzp) begin
          failures++;
          $display("FAIL nzp step=%0d actual=%b required=%b", e.id, {n_f, z_f, p_f}, e.nzp);
        end
        checks++;
        if (ben !== e.ben) begin
          failures++;
          $display("FAIL ben step=%0d actual=%b required=%b", e.id, ben, e.ben);
        end
      end
    end
  end

  initial begin
    logic [15:0] rb;
    int          pick;
    rst_n  = 1'b0;
    bus    = 16'h0000;
    ir     = 16'h0000;
    ld_reg = 1'b0;
    drmux  = 2'b00;
    sr1mux = 2'b00;
    ld_cc  = 1'b0;
    ld_ben = 1'b0;
    model_reset();

    // Reset held with every load strobe active.
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 16'hFFFF, 16'((k << 9) | k), 1'b1, 2'b00, 2'b00, 1'b1, 1'b1);
    end
    step(1'b1, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // Write R3 via IR[11:9]; old value visible before the edge.
    step(1'b1, 16'hBEEF, 16'h0600, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 16'h0600, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    sweep(1'b1);

    // SR2 immediate and register paths.
    step(1'b1, 16'h0000, 16'h0033, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 16'h0027, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 16'h0003, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // CC loads, then a bus value with no strobe.
    step(1'b1, 16'h8000, 16'h0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    step(1'b1, 16'h7FFF, 16'h0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    step(1'b1, 16'h8000, 16'h0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 16'h8000, 16'h0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // BEN with simultaneous CC load, then BEN alone.
    step(1'b1, 16'h8000, 16'h0200, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
    step(1'b1, 16'h0000, 16'h0200, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    step(1'b1, 16'h0000, 16'h0200, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // DRMUX R7, R6, reserved; SR1MUX R6 and reserved.
    step(1'b1, 16'h1234, 16'h0000, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    step(1'b1, 16'h5678, 16'h0000, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0);
    step(1'b1, 16'h9999, 16'h0E00, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0);
    sweep(1'b1);

    // Register write and CC load from one bus value.
    step(1'b1, 16'hFF00, 16'h0A00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 16'h0A00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // Mid-operation reset with loads asserted.
    step(1'b0, 16'hAAAA, 16'h0E00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1);
    sweep(1'b0);
    step(1'b1, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      pick = int'($urandom_range(0, 5));
      if (pick == 0)      rb = 16'h0000;
      else if (pick == 1) rb = 16'h8000;
      else if (pick == 2) rb = 16'h7FFF;
      else                rb = 16'($urandom);
      step(($urandom_range(0, 39) != 0), rb, 16'($urandom),
           ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0));
    end
    sweep(1'b1);

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_cc.md
Name: reg_file_cc

Overview:
- Operand source and result sink on the datapath side of the ALU.
- Holds the eight 16-bit general-purpose registers R0–R7 and writes bus values into them.
- Drives both ALU operand inputs: SR1 from a register, SR2 from a register or sign-extended imm5.
- Holds the NZP condition-code register and the BEN branch-enable flag used by the control store.

Parameters:
- DATA_W, 16, datapath and register width.
- NUM_REGS, 8, number of general-purpose registers.
- RESET_NZP, 3'b010, NZP value after reset (Z set).

Ports:
- i_Clk  input  1  system clock; all state updates on the rising edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Bus  input  16  shared bus value; write-back data and CC source.
- i_IR  input  16  current instruction register.
- i_LD_REG  input  1  write i_Bus into the destination register selected by i_DRMUX.
- i_DRMUX  input  2  destination select: 00 IR[11:9], 01 R7, 10 R6, 11 reserved (no write).
- i_SR1MUX  input  2  SR1 select: 00 IR[11:9], 01 IR[8:6], 10 R6, 11 reserved (reads R0).
- i_LD_CC  input  1  load NZP from i_Bus.
- i_LD_BEN  input  1  load BEN.
- o_SR1_Out  output  16  R[SR1]; drives the ALU register-file operand.
- o_SR2_Out  output  16  SR2 mux output; drives the ALU SR2 operand.
- o_N, o_Z, o_P  output  1 each  condition-code flags.
- o_BEN  output  1  branch-enable flag.

Behaviour:
- Reset: i_Rst_n low asynchronously forces the following, and this state holds while i_Rst_n is low:
  - R0–R7 = 16'h0000.
  - {N,Z,P} = RESET_NZP.
  - BEN = 0.
- Reset mid-operation overrides any load asserted in the same cycle.
- Register write: on a rising edge with i_LD_REG=1 and i_DRMUX≠11, R[dest] <= i_Bus. Exactly one register changes. i_DRMUX=11 writes nothing.
- Read ports are combinational from registered state; there is no write-to-read bypass.
  - In the cycle of a write, the outputs show the old value.
  - The new value is visible after the edge.
- o_SR1_Out = R[sr1], where sr1 is taken from i_SR1MUX.
- o_SR2_Out:
  - If IR[5]=1: sign-extended IR[4:0] to 16 bits (bit 4 replicated into [15:5]).
  - Otherwise: R[IR[2:0]].
- CC load: on an edge with i_LD_CC=1, the new NZP comes from i_Bus:
  - N = bus[15].
  - Z = (bus==0).
  - P = !bus[15] && bus≠0.
  - Exactly one flag is set after any load.
- BEN load: on an edge with i_LD_BEN=1, BEN <= (IR[11]&N) | (IR[10]&Z) | (IR[9]&P), using the NZP value held before that edge.
- Simultaneous i_LD_CC and i_LD_BEN: BEN uses the old NZP; NZP updates in the same edge.
- Simultaneous i_LD_REG and i_LD_CC: both take effect from the same i_Bus value.
- Loads with no strobe asserted: all state holds.
- Latency: one edge from load strobe to updated output. Reads have zero latency.

Decomposition:
- Shared package (lc3_pkg) holds:
  - DRMUX encodings: DR_IR11_9, DR_R7, DR_R6.
  - SR1MUX encodings: SR1_IR11_9, SR1_IR8_6, SR1_R6.
  - DATA_W.
  - RESET_NZP.
- One natural sub-module, nzp_logic: combinational N/Z/P generation from a 16-bit value, reused by the PSR/interrupt path later.
- The register array, operand muxes, and BEN logic stay inline.

Test Plan:
- Reset: assert i_Rst_n=0 mid-cycle with i_LD_REG=1 -> all registers read 0000, {N,Z,P}=010 and BEN=0 immediately, without waiting for a clock edge.
- Write/read, no bypass: DRMUX=00, IR[11:9]=3, bus=16'hBEEF, LD_REG=1:
  - SR1MUX=00 before the edge -> o_SR1_Out=0000.
  - After the edge -> o_SR1_Out=BEEF; R0–R2 and R4–R7 remain 0.
- SR2 immediate: IR[5]=1, IR[4:0]=5'b10011 -> o_SR2_Out=FFF3. IR[4:0]=5'b00111 -> 0007. IR[5]=0, IR[2:0]=3 -> R3.
- CC load: bus values 8000, 0000, 7FFF with LD_CC=1 -> NZP = 100, 010, 001 after the respective edges. With LD_CC=0 and bus=8000 -> NZP unchanged.
- BEN with simultaneous CC load: NZP=001, IR[11:9]=001, bus=8000, LD_CC=1 and LD_BEN=1 on the same edge -> BEN=1 (old P used) and NZP=100. Repeat LD_BEN alone -> BEN=0.
- DRMUX R7/R6 and reserved: DRMUX=01, bus=1234 -> R7=1234. DRMUX=10 -> R6. DRMUX=11 -> no register changes.
